// File: rtl/sparc_ram_loader.sv
// rtl/sparc_ram_loader.sv - boot loader streaming bytes into SPARC_MPU RAM over MOV/MFC
module sparc_ram_loader #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 8,
   parameter int BASE_ADDR   = 0,
   parameter int MFC_TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              Start,
   input  logic [DATA_W-1:0] InData,
   input  logic              InValid,
   input  logic              InLast,
   output logic              InReady,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemData,
   output logic              MemMOV,
   output logic              MemRW,
   output logic [1:0]        MemType,
   input  logic              MemMFC,
   output logic              CpuClr,
   output logic              Done,
   output logic              Error,
   output logic [ADDR_W:0]   ByteCount
);

   localparam int                CNT_W    = $clog2(MFC_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_WAIT_MFC,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_mov_q, mem_mov_d;
   logic              cpu_clr_q, cpu_clr_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [ADDR_W:0]   byte_count_q, byte_count_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b0;
         mem_addr_q   <= BASE;
         mem_data_q   <= '0;
         mem_mov_q    <= 1'b0;
         cpu_clr_q    <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         byte_count_q <= '0;
         cnt_q        <= '0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_mov_q    <= mem_mov_d;
         cpu_clr_q    <= cpu_clr_d;
         done_q       <= done_d;
         error_q      <= error_d;
         byte_count_q <= byte_count_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_mov_d    = mem_mov_q;
      cpu_clr_d    = cpu_clr_q;
      done_d       = done_q;
      error_d      = error_q;
      byte_count_d = byte_count_q;
      cnt_d        = cnt_q;
      last_d       = last_q;

      case (state_q)
         // A session can be (re)started only from the quiescent states.
         S_IDLE, S_DONE, S_ERR: begin
            if (Start) begin
               state_d      = S_RECV;
               in_ready_d   = 1'b1;
               mem_addr_d   = BASE;
               byte_count_d = '0;
               done_d       = 1'b0;
               error_d      = 1'b0;
               cpu_clr_d    = 1'b1;
            end
         end
         S_RECV: begin
            if (InValid && in_ready_q) begin
               mem_data_d = InData;
               last_d     = InLast;
               in_ready_d = 1'b0;
               mem_mov_d  = 1'b1;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            cnt_d   = '0;
            state_d = S_WAIT_MFC;
         end
         S_WAIT_MFC: begin
            if (MemMFC) begin
               mem_mov_d    = 1'b0;
               byte_count_d = byte_count_q + (ADDR_W + 1)'(1);
               if (last_q) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  cpu_clr_d = 1'b0;
               end else if (mem_addr_q == ADDR_MAX) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else begin
                  mem_addr_d = mem_addr_q + ADDR_W'(1);
                  in_ready_d = 1'b1;
                  state_d    = S_RECV;
               end
            end else if (cnt_q == CNT_LAST) begin
               mem_mov_d = 1'b0;
               state_d   = S_ERR;
               error_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign InReady   = in_ready_q;
   assign MemAddr   = mem_addr_q;
   assign MemData   = mem_data_q;
   assign MemMOV    = mem_mov_q;
   assign MemRW     = 1'b0;
   assign MemType   = 2'b00;
   assign CpuClr    = cpu_clr_q;
   assign Done      = done_q;
   assign Error     = error_q;
   assign ByteCount = byte_count_q;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// tb/tb_sparc_ram_loader.sv - randomized bench for sparc_ram_loader with a RAM/MFC responder model
module tb_sparc_ram_loader;

   localparam int ADDR_W      = 9;
   localparam int DATA_W      = 8;
   localparam int BASE_ADDR   = 0;
   localparam int MFC_TIMEOUT = 15;
   localparam int RAM_BYTES   = 1 << ADDR_W;
   localparam int NEVER       = 1000;

   logic              Clk = 1'b0;
   logic              Clr = 1'b1;
   logic              Start = 1'b0;
   logic [DATA_W-1:0] InData = '0;
   logic              InValid = 1'b0;
   logic              InLast = 1'b0;
   logic              InReady;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemData;
   logic              MemMOV;
   logic              MemRW;
   logic [1:0]        MemType;
   logic              MemMFC = 1'b0;
   logic              CpuClr;
   logic              Done;
   logic              Error;
   logic [ADDR_W:0]   ByteCount;

   sparc_ram_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .MFC_TIMEOUT(MFC_TIMEOUT)
   ) dut (
      .Clk(Clk), .Clr(Clr), .Start(Start), .InData(InData), .InValid(InValid),
      .InLast(InLast), .InReady(InReady), .MemAddr(MemAddr), .MemData(MemData),
      .MemMOV(MemMOV), .MemRW(MemRW), .MemType(MemType), .MemMFC(MemMFC),
      .CpuClr(CpuClr), .Done(Done), .Error(Error), .ByteCount(ByteCount)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // RAM model: MFC returns mfc_delay cycles after MemMOV rises; every completed write is logged.
   int              mfc_delay = 1;
   int              mov_age = 0;
   int              mov_rises = 0;
   int              rdy_viol = 0;
   int              mfc_cyc = 0;
   int              mov_lens[$];
   logic [ADDR_W-1:0] wr_addr[$];
   logic [DATA_W-1:0] wr_data[$];

   always @(negedge Clk) begin
      if (MemMOV === 1'b1) begin
         if (mov_age == 0) mov_rises++;
         mov_age++;
         if (InReady === 1'b1) rdy_viol++;
         MemMFC = (mov_age == mfc_delay + 1);
         if (MemMFC) begin
            wr_addr.push_back(MemAddr);
            wr_data.push_back(MemData);
            mfc_cyc = cyc;
         end
      end else begin
         if (mov_age > 0) mov_lens.push_back(mov_age);
         mov_age = 0;
         MemMFC  = 1'b0;
      end
   end

   logic [DATA_W-1:0] tx_q[$];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic push_byte(input logic [DATA_W-1:0] d, input logic l, input int budget,
                            output bit ok, output int acc_cyc);
      InData = d; InValid = 1'b1; InLast = l; ok = 1'b0; acc_cyc = -1;
      for (int t = 0; t < budget && !ok; t++) begin
         @(negedge Clk);
         if (InReady === 1'b1) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end
         tick();
      end
      InValid = 1'b0; InLast = 1'b0;
   endtask

   task automatic wait_end(input int budget, output int ecyc);
      bit found;
      found = 1'b0;
      ecyc = -1;
      for (int t = 0; t < budget && !found; t++) begin
         @(negedge Clk);
         if (Done === 1'b1 || Error === 1'b1) begin
            found = 1'b1;
            ecyc = cyc;
         end
         tick();
      end
      check("end_wait", int'(found), 1);
   endtask

   task automatic reset_checks();
      check("rst_inready", int'(InReady), 0);
      check("rst_mov", int'(MemMOV), 0);
      check("rst_rw", int'(MemRW), 0);
      check("rst_type", int'(MemType), 0);
      check("rst_addr", int'(MemAddr), BASE_ADDR);
      check("rst_data", int'(MemData), 0);
      check("rst_cpuclr", int'(CpuClr), 1);
      check("rst_done", int'(Done), 0);
      check("rst_error", int'(Error), 0);
      check("rst_bcount", int'(ByteCount), 0);
   endtask

   // Expected outcome of a session follows directly from the stream: the first min(n, RAM) bytes
   // land at consecutive addresses, Done only if InLast arrives within RAM, else overflow error.
   task automatic run_session(input int d, input bit with_last, input bit gaps, input bit chk_int);
      int n, nw, i0, m0, r0, acc, prev, ecyc;
      bit ok, exp_done;
      n  = tx_q.size();
      nw = (n > RAM_BYTES) ? RAM_BYTES : n;
      exp_done = with_last && (n <= RAM_BYTES);
      mfc_delay = d;
      i0 = wr_addr.size(); m0 = mov_lens.size(); r0 = mov_rises;
      pulse_start();
      prev = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         if (i < RAM_BYTES) begin
            push_byte(tx_q[i], with_last && (i == n - 1), 200, ok, acc);
            check("accept", int'(ok), 1);
            if (!ok) break;
            if (chk_int && i > 0) check("acc_gap", acc - prev, d + 2);
            prev = acc;
         end else begin
            push_byte(tx_q[i], 1'b0, 40, ok, acc);
            check("acc_ovf", int'(ok), 0);
         end
      end
      wait_end(200 + 20 * d, ecyc);
      if (exp_done) check("done_lat", ecyc - mfc_cyc, 1);
      check("n_wr", wr_addr.size() - i0, nw);
      for (int k = 0; k < nw && i0 + k < wr_addr.size(); k++) begin
         check("wr_addr", int'(wr_addr[i0 + k]), BASE_ADDR + k);
         check("wr_data", int'(wr_data[i0 + k]), int'(tx_q[k]));
      end
      check("n_issue", mov_rises - r0, nw);
      for (int k = m0; k < mov_lens.size(); k++) check("mov_len", mov_lens[k], d + 1);
      check("bcount", int'(ByteCount), nw);
      check("done", int'(Done), int'(exp_done));
      check("error", int'(Error), int'(!exp_done));
      check("cpuclr", int'(CpuClr), int'(!exp_done));
      check("inready_end", int'(InReady), 0);
      check("mov_end", int'(MemMOV), 0);
      check("rdy_during_mov", rdy_viol, 0);
   endtask

   task automatic fill_random(input int n);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(DATA_W'($urandom));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int i0, m0, ecyc, acc, seen;
      bit ok;
      logic [DATA_W-1:0] x;

      Clr = 1'b1;
      tick();
      tick();
      Clr = 1'b0;
      @(negedge Clk);
      reset_checks();
      tick();

      tx_q = '{8'h8A, 8'h10, 8'h20, 8'h03};
      run_session(1, 1'b1, 1'b0, 1'b1);

      fill_random(4);
      run_session(5, 1'b1, 1'b0, 1'b1);

      fill_random(2);
      run_session(MFC_TIMEOUT, 1'b1, 1'b0, 1'b1);

      // Pending byte while in DONE must wait for the next Start.
      x = DATA_W'($urandom);
      InData = x; InValid = 1'b1; InLast = 1'b1;
      i0 = wr_addr.size();
      seen = 0;
      repeat (8) begin
         @(negedge Clk);
         if (InReady === 1'b1) seen++;
         tick();
      end
      check("rdy_in_done", seen, 0);
      check("done_hold", int'(Done), 1);
      check("no_wr_in_done", wr_addr.size() - i0, 0);
      mfc_delay = 1;
      pulse_start();
      @(negedge Clk);
      check("restart_cpuclr", int'(CpuClr), 1);
      check("restart_done", int'(Done), 0);
      check("restart_inready", int'(InReady), 1);
      tick();
      InValid = 1'b0; InLast = 1'b0;
      wait_end(100, ecyc);
      check("pend_n_wr", wr_addr.size() - i0, 1);
      if (wr_addr.size() > i0) begin
         check("pend_addr", int'(wr_addr[i0]), BASE_ADDR);
         check("pend_data", int'(wr_data[i0]), int'(x));
      end
      check("pend_bcount", int'(ByteCount), 1);
      check("pend_done", int'(Done), 1);
      check("pend_cpuclr", int'(CpuClr), 0);

      // MFC never returns.
      mfc_delay = NEVER;
      i0 = wr_addr.size(); m0 = mov_lens.size();
      pulse_start();
      push_byte(DATA_W'($urandom), 1'b1, 200, ok, acc);
      check("to_accept", int'(ok), 1);
      wait_end(100, ecyc);
      check("to_error", int'(Error), 1);
      check("to_mov", int'(MemMOV), 0);
      check("to_cpuclr", int'(CpuClr), 1);
      check("to_done", int'(Done), 0);
      check("to_bcount", int'(ByteCount), 0);
      check("to_n_wr", wr_addr.size() - i0, 0);
      check("to_bursts", mov_lens.size() - m0, 1);
      if (mov_lens.size() > m0) check("to_mov_len", mov_lens[m0], MFC_TIMEOUT + 1);
      pulse_start();
      @(negedge Clk);
      check("to_restart_err", int'(Error), 0);
      check("to_restart_addr", int'(MemAddr), BASE_ADDR);
      check("to_restart_rdy", int'(InReady), 1);
      check("to_restart_bcnt", int'(ByteCount), 0);
      tick();
      fill_random(2);
      run_session(2, 1'b1, 1'b1, 1'b0);

      for (int s = 0; s < 6; s++) begin
         fill_random($urandom_range(1, 8));
         run_session($urandom_range(1, MFC_TIMEOUT), 1'b1, s[0], !s[0]);
      end

      // Clr during the MFC wait of the second byte.
      mfc_delay = 1;
      pulse_start();
      push_byte(DATA_W'($urandom), 1'b0, 200, ok, acc);
      check("clr_acc0", int'(ok), 1);
      push_byte(DATA_W'($urandom), 1'b0, 200, ok, acc);
      check("clr_acc1", int'(ok), 1);
      mfc_delay = NEVER;
      repeat (3) tick();
      @(negedge Clk);
      check("clr_pre_mov", int'(MemMOV), 1);
      tick();
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      @(negedge Clk);
      reset_checks();
      tick();
      fill_random(3);
      run_session(1, 1'b1, 1'b0, 1'b1);

      fill_random(RAM_BYTES + 1);
      run_session(1, 1'b0, 1'b0, 1'b1);
      check("ovf_addr", int'(MemAddr), RAM_BYTES - 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
